// File: rtl/sobel_stream_window_if.sv
// rtl/sobel_stream_window_if.sv - pixel-in / window-out handshake bundle
// Purpose: groups the upstream pixel stream and the downstream window stream.
// Signals:
//   s_valid, s_data, s_ready          upstream raster pixel stream
//   m_valid, m_ready, m_win           downstream 3x3 window stream
//   m_x, m_y, m_last                  window centre and end-of-frame flag
// Modports: slave = window block side, master = environment side.
interface sobel_stream_window_if #(
  parameter int IMAGE_WIDTH_E = 9,
  parameter int IMAGE_HIGHT_E = 9,
  parameter int BYTE_SIZE     = 8
);
  logic                     s_valid;
  logic [BYTE_SIZE-1:0]     s_data;
  logic                     s_ready;
  logic                     m_valid;
  logic                     m_ready;
  logic [9*BYTE_SIZE-1:0]   m_win;
  logic [IMAGE_WIDTH_E-1:0] m_x;
  logic [IMAGE_HIGHT_E-1:0] m_y;
  logic                     m_last;

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_win, m_x, m_y, m_last
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_win, m_x, m_y, m_last
  );
endinterface

// File: rtl/sobel_stream_window.sv
// rtl/sobel_stream_window.sv - raster pixel stream to zero-padded 3x3 windows
// Purpose: buffers lines in three rotating banks and emits one 3x3
//   neighbourhood per pixel in raster order of the window centre.
// Ports:
//   clk    single rising-edge clock
//   reset  synchronous active-low reset
//   io     sobel_stream_window_if.slave (pixel in, window out)
module sobel_stream_window #(
  parameter int IMAGE_WIDTH_E = 9,
  parameter int IMAGE_HIGHT_E = 9,
  parameter int BYTE_SIZE     = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  sobel_stream_window_if.slave  io
);
  localparam int IMAGE_WIDTH = 2 ** IMAGE_WIDTH_E;
  localparam int IMAGE_HIGHT = 2 ** IMAGE_HIGHT_E;
  localparam int BW          = IMAGE_WIDTH_E + 2;

  typedef logic [IMAGE_WIDTH_E-1:0] x_t;
  typedef logic [IMAGE_HIGHT_E-1:0] y_t;
  typedef logic [BW-1:0]            bcnt_t;
  typedef logic [BYTE_SIZE-1:0]     pix_t;

  localparam x_t    X_LAST = x_t'(IMAGE_WIDTH - 1);
  localparam x_t    X_ONE  = x_t'(1);
  localparam y_t    Y_LAST = y_t'(IMAGE_HIGHT - 1);
  localparam y_t    Y_ONE  = y_t'(1);
  localparam bcnt_t B_W    = bcnt_t'(IMAGE_WIDTH);
  localparam bcnt_t B_ONE  = bcnt_t'(1);

  typedef enum logic [1:0] {FILL, RUN, EOL, BOTTOM} state_t;

  state_t r_state, w_state_next;
  x_t     r_x;
  y_t     r_y;
  logic [1:0] r_ptr;      // bank receiving the current line
  bcnt_t  r_bcnt;         // bottom-line step count, W+1 means waiting for m_last handshake

  pix_t r_bank [3][IMAGE_WIDTH];
  // Two stored columns; the third (right) column is the incoming one, so the
  // window is complete at the step that forms it.
  pix_t r_sh_a [3];
  pix_t r_sh_b [3];

  logic                   r_m_valid;
  logic [9*BYTE_SIZE-1:0] r_m_win;
  x_t                     r_m_x;
  y_t                     r_m_y;
  logic                   r_m_last;

  logic       w_out_free, w_s_rdy, w_acc;
  logic [1:0] w_ptr_y1, w_ptr_y2;
  x_t         w_rd_x;
  pix_t       w_rd_y1, w_rd_y2;
  logic       w_step, w_first, w_form, w_last;
  pix_t       w_col [3];
  x_t         w_cx;
  y_t         w_cy;
  logic [9*BYTE_SIZE-1:0] w_win;

  assign w_out_free = !r_m_valid || io.m_ready;
  assign w_s_rdy    = reset && ((r_state == FILL) || (r_state == RUN && w_out_free));
  assign w_acc      = io.s_valid && w_s_rdy;

  // Line y-1 sits in the bank before the pointer, line y-2 in the one after it.
  assign w_ptr_y1 = (r_ptr == 2'd0) ? 2'd2 : r_ptr - 2'd1;
  assign w_ptr_y2 = (r_ptr == 2'd2) ? 2'd0 : r_ptr + 2'd1;
  assign w_rd_x   = (r_state == BOTTOM) ? r_bcnt[IMAGE_WIDTH_E-1:0] : r_x;
  assign w_rd_y1  = r_bank[w_ptr_y1][w_rd_x];
  assign w_rd_y2  = r_bank[w_ptr_y2][w_rd_x];

  always_ff @(posedge clk) begin
    if (!reset) r_state <= FILL;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_step       = 1'b0;
    w_first      = 1'b0;
    w_form       = 1'b0;
    w_last       = 1'b0;
    w_col        = '{default: '0};
    w_cx         = '0;
    w_cy         = '0;
    case (r_state)
      FILL: begin
        if (w_acc && r_x == X_LAST)
          w_state_next = (IMAGE_HIGHT == 1) ? BOTTOM : RUN;
      end
      RUN: begin
        if (w_acc) begin
          w_step   = 1'b1;
          w_first  = (r_x == '0);
          w_form   = (r_x != '0);
          // Line -1 is padding; never trust bank contents for it.
          w_col[0] = (r_y == Y_ONE) ? '0 : w_rd_y2;
          w_col[1] = w_rd_y1;
          w_col[2] = io.s_data;
          w_cx     = r_x - X_ONE;
          w_cy     = r_y - Y_ONE;
          if (r_x == X_LAST) w_state_next = EOL;
        end
      end
      EOL: begin
        if (w_out_free) begin
          w_step       = 1'b1;
          w_form       = 1'b1;
          w_cx         = X_LAST;
          w_cy         = r_y - Y_ONE;
          w_state_next = (r_y == Y_LAST) ? BOTTOM : RUN;
        end
      end
      BOTTOM: begin
        if (r_bcnt <= B_W) begin
          if (w_out_free) begin
            w_step  = 1'b1;
            w_first = (r_bcnt == '0);
            w_form  = (r_bcnt != '0);
            if (r_bcnt < B_W) begin
              w_col[0] = (IMAGE_HIGHT == 1) ? '0 : w_rd_y2;
              w_col[1] = w_rd_y1;
            end
            w_cx   = r_bcnt[IMAGE_WIDTH_E-1:0] - X_ONE;
            w_cy   = Y_LAST;
            w_last = (r_bcnt == B_W);
          end
        end else if (r_m_valid && io.m_ready) begin
          w_state_next = FILL;
        end
      end
      default: w_state_next = FILL;
    endcase
  end

  always_comb begin
    w_win = '0;
    for (int r = 0; r < 3; r++) begin
      w_win[BYTE_SIZE*(3*r+0) +: BYTE_SIZE] = w_first ? '0 : r_sh_a[r];
      w_win[BYTE_SIZE*(3*r+1) +: BYTE_SIZE] = w_first ? '0 : r_sh_b[r];
      w_win[BYTE_SIZE*(3*r+2) +: BYTE_SIZE] = w_col[r];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_x    <= '0;
      r_y    <= '0;
      r_ptr  <= 2'd0;
      r_bcnt <= '0;
    end else begin
      if (w_acc) begin
        r_x <= r_x + X_ONE;
        if (r_x == X_LAST) r_ptr <= w_ptr_y2;
      end
      if (r_state == FILL && w_acc && r_x == X_LAST)
        r_y <= (IMAGE_HIGHT == 1) ? '0 : Y_ONE;
      if (r_state == EOL && w_step && r_y != Y_LAST)
        r_y <= r_y + Y_ONE;
      if (r_state == BOTTOM && w_step)
        r_bcnt <= r_bcnt + B_ONE;
      if (r_state == BOTTOM && w_state_next == FILL) begin
        r_bcnt <= '0;
        r_y    <= '0;
        r_x    <= '0;
        r_ptr  <= 2'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_acc) r_bank[r_ptr][r_x] <= io.s_data;
  end

  // A first step (x = 0) discards the previous line's columns so the left
  // column of the x = 0 window is padding.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sh_a <= '{default: '0};
      r_sh_b <= '{default: '0};
    end else if (w_step) begin
      for (int r = 0; r < 3; r++) begin
        r_sh_a[r] <= w_first ? '0 : r_sh_b[r];
        r_sh_b[r] <= w_col[r];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_m_valid <= 1'b0;
      r_m_win   <= '0;
      r_m_x     <= '0;
      r_m_y     <= '0;
      r_m_last  <= 1'b0;
    end else if (w_out_free) begin
      r_m_valid <= w_form;
      if (w_form) begin
        r_m_win  <= w_win;
        r_m_x    <= w_cx;
        r_m_y    <= w_cy;
        r_m_last <= w_last;
      end
    end
  end

  assign io.s_ready = w_s_rdy;
  assign io.m_valid = r_m_valid;
  assign io.m_win   = r_m_win;
  assign io.m_x     = r_m_x;
  assign io.m_y     = r_m_y;
  assign io.m_last  = r_m_last;
endmodule

// File: tb/tb_sobel_stream_window.sv
// tb/tb_sobel_stream_window.sv - scoreboard bench for sobel_stream_window
module tb_sobel_stream_window;
  localparam int WE = 2;
  localparam int HE = 2;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int B  = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  sobel_stream_window_if #(.IMAGE_WIDTH_E(WE), .IMAGE_HIGHT_E(HE), .BYTE_SIZE(B)) bus ();

  sobel_stream_window #(.IMAGE_WIDTH_E(WE), .IMAGE_HIGHT_E(HE), .BYTE_SIZE(B)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus)
  );

  typedef struct {
    logic [71:0] win;
    int          x;
    int          y;
    logic        last;
    int          kind;
  } exp_t;

  exp_t        sbq[$];
  int          total = 0;
  int          bad   = 0;
  logic [7:0]  img [H][W];
  int          rdy_mode = 0;
  int          hold_cnt = 0;
  logic [76:0] snap;

  task automatic chk(input string name, input logic [76:0] got, input logic [76:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int x, input int y);
    if (x < 0 || x >= W || y < 0 || y >= H) return 8'd0;
    return img[y][x];
  endfunction

  // A window (cx,cy) exists once pixel (min(cx+1,W-1), cy+1) is in; bottom
  // line windows need the whole frame.
  task automatic push_frame(input int kind, input int npix);
    for (int cy = 0; cy < H; cy++) begin
      for (int cx = 0; cx < W; cx++) begin
        int k;
        exp_t e;
        k = (cy + 1) * W + ((cx + 1 < W) ? cx + 1 : W - 1);
        if ((cy == H - 1) ? (npix >= W * H) : (k < npix)) begin
          e.win = '0;
          for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
              e.win[8*(3*r+c) +: 8] = pix(cx + c - 1, cy + r - 1);
          e.x    = cx;
          e.y    = cy;
          e.last = (cx == W - 1 && cy == H - 1);
          e.kind = kind;
          sbq.push_back(e);
        end
      end
    end
  endtask

  // kind 0: 16y+x+1, kind 1: 100+x, kind 2: random. bubble 1: toggle, 2: random gaps.
  task automatic send_frame(input int kind, input int bubble, input int npix);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        img[y][x] = (kind == 0) ? 8'(16 * y + x + 1) :
                    (kind == 1) ? 8'(100 + x) : 8'($urandom_range(0, 255));
    push_frame(kind, npix);
    for (int i = 0; i < npix; i++) begin
      int n;
      if (bubble == 1 && i > 0) begin
        bus.s_valid = 1'b0;
        @(posedge clk); #1;
      end else if (bubble == 2) begin
        bus.s_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      bus.s_valid = 1'b1;
      bus.s_data  = img[i / W][i % W];
      n = 0;
      forever begin
        @(negedge clk);
        if (bus.s_ready) begin
          if (i < W) chk("fill_quiet", 77'(bus.m_valid), 77'(0));
          @(posedge clk); #1;
          break;
        end
        @(posedge clk); #1;
        n++;
        if (n > 300) begin
          total++; bad++;
          $display("FAIL accept_timeout pixel=%0d got no s_ready required s_ready=1", i);
          break;
        end
      end
      if (i == W + 1)
        chk("first_latency", 77'({bus.m_valid, bus.m_x, bus.m_y}), 77'({1'b1, 2'd0, 2'd0}));
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", 77'(sbq.size()), 77'(0));
  endtask

  always begin
    @(posedge clk); #1;
    case (rdy_mode)
      2: begin
        if (bus.m_valid && bus.m_x == 2'd1 && bus.m_y == 2'd1 && hold_cnt < 5) begin
          if (hold_cnt == 0) snap = {bus.m_win, bus.m_x, bus.m_y, bus.m_last};
          bus.m_ready = 1'b0;
          hold_cnt++;
          @(negedge clk);
          chk("stall_hold", {bus.m_win, bus.m_x, bus.m_y, bus.m_last}, snap);
          chk("stall_sready", 77'(bus.s_ready), 77'(0));
        end else begin
          bus.m_ready = 1'b1;
        end
      end
      3:       bus.m_ready = ($urandom_range(0, 3) != 0);
      default: bus.m_ready = 1'b1;
    endcase
  end

  always @(negedge clk) begin
    if (bus.m_valid && bus.m_ready) begin
      if (sbq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_window got x=%0d y=%0d required none", bus.m_x, bus.m_y);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("win", 77'(bus.m_win), 77'(e.win));
        chk("pos", 77'({bus.m_x, bus.m_y}), 77'({e.x[1:0], e.y[1:0]}));
        chk("last", 77'(bus.m_last), 77'(e.last));
        if (e.kind == 0 && e.x == 0 && e.y == 0)
          chk("plan_first", 77'(bus.m_win),
              77'({8'd18, 8'd17, 8'd0, 8'd2, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0}));
        if (e.kind == 0 && e.last)
          chk("plan_last", 77'(bus.m_win),
              77'({24'd0, 8'd0, 8'd52, 8'd51, 8'd0, 8'd36, 8'd35}));
        if (e.kind == 1 && e.y == 0)
          chk("b2b_top_zero", 77'(bus.m_win[23:0]), 77'(0));
        if (e.kind == 1 && e.last)
          chk("b2b_bottom_zero", 77'(bus.m_win[71:48]), 77'(0));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no finish required finish");
    $fatal(1);
  end

  initial begin
    bus.s_valid = 1'b1;
    bus.s_data  = 8'hAA;
    reset       = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_m_valid", 77'(bus.m_valid), 77'(0));
      chk("rst_m_win", 77'(bus.m_win), 77'(0));
      chk("rst_s_ready", 77'(bus.s_ready), 77'(0));
    end
    @(posedge clk); #1;
    reset       = 1'b1;
    bus.s_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_s_ready", 77'(bus.s_ready), 77'(1));
    @(posedge clk); #1;

    rdy_mode = 0;
    send_frame(0, 0, W * H);
    wait_drain();

    rdy_mode = 2;
    hold_cnt = 0;
    send_frame(0, 0, W * H);
    wait_drain();
    chk("stall_cycles", 77'(hold_cnt), 77'(5));

    rdy_mode = 0;
    send_frame(0, 1, W * H);
    wait_drain();

    send_frame(0, 0, 2 * W + 3);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    wait_drain();

    send_frame(0, 0, W * H);
    send_frame(1, 0, W * H);
    wait_drain();

    rdy_mode = 3;
    repeat (3) send_frame(2, 2, W * H);
    wait_drain();
    rdy_mode = 0;
    repeat (5) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sobel_stream_window.md
Name: sobel_stream_window

Overview:
- Streaming front end for the Sobel datapath. It accepts a raster-scan 8-bit pixel stream with a valid/ready handshake.
- It writes the pixels into three rotating line banks and emits one zero-padded 3x3 neighbourhood per pixel, also on valid/ready.
- It replaces the bulk image-array load. The Sobel arithmetic block consumes its window output directly.

Parameters:
- IMAGE_WIDTH_E, 9, log2 of image width in pixels.
- IMAGE_HIGHT_E, 9, log2 of image height in lines.
- IMAGE_WIDTH, 2**IMAGE_WIDTH_E, pixels per line (derived).
- IMAGE_HIGHT, 2**IMAGE_HIGHT_E, lines per frame (derived).
- BYTE_SIZE, 8, pixel width in bits.

Ports:
- clk  in  1  single clock, all logic on its rising edge.
- reset  in  1  synchronous, active-low reset. Sampled on the rising edge of clk, 0 = reset.
- s_valid  in  1  upstream pixel valid.
- s_data  in  BYTE_SIZE  upstream pixel, raster order: line 0 first, x = 0 first.
- s_ready  out  1  block accepts s_data this cycle. Transfer occurs when s_valid && s_ready.
- m_valid  out  1  window valid.
- m_ready  in  1  downstream accepts the window.
- m_win  out  9*BYTE_SIZE  3x3 window. Pixel (row r, col c) sits at bits [BYTE_SIZE*(3r+c) +: BYTE_SIZE]; r = 0 is the top row, c = 0 is the left column.
- m_x  out  IMAGE_WIDTH_E  centre column of the window.
- m_y  out  IMAGE_HIGHT_E  centre line of the window.
- m_last  out  1  high only with the window centred at (IMAGE_WIDTH-1, IMAGE_HIGHT-1).

Behaviour:
- Reset (reset == 0 at a clk edge):
  - state = FILL; x/y counters = 0; bank pointer = 0.
  - m_valid = 0; m_win = 0; m_x = 0; m_y = 0; m_last = 0.
  - s_ready = 0 while reset is asserted.
  - A partial frame is discarded. The next accepted pixel is (0,0) of a new frame.
- Storage:
  - Three banks of IMAGE_WIDTH x BYTE_SIZE. The incoming line is written into the bank holding line y-3.
  - A read of a bank location happens before a write to it in the same cycle.
  - The pointer rotates when a line completes.
- Column shifter:
  - 3x3 register. Each step shifts left and loads a new right column {line y-2[x], line y-1[x], incoming pixel}.
  - Any term outside the image reads 0: line -1 and below line IMAGE_HIGHT-1.
  - The left column of the window centred at x = 0 is 0. This matches the zero padding used by the Sobel kernel.
- States:
  - FILL:
    - s_ready = 1; accepts line 0 into a bank; no window output.
    - After x = IMAGE_WIDTH-1 is accepted: go to RUN, y = 1.
    - If IMAGE_HIGHT == 1, go to BOTTOM instead.
  - RUN:
    - s_ready = !m_valid || m_ready.
    - Each accepted pixel (x,y) steps the shifter. For x >= 1, the window centred at (x-1, y-1) is registered onto the output next cycle.
    - After x = IMAGE_WIDTH-1 is accepted: go to EOL.
  - EOL:
    - s_ready = 0. One step with a zero incoming column emits the window centred at (IMAGE_WIDTH-1, y-1).
    - Then: if y < IMAGE_HIGHT-1, increment y and go to RUN; else go to BOTTOM.
  - BOTTOM:
    - s_ready = 0. Steps internally through x = 0..IMAGE_WIDTH-1 using banks for lines IMAGE_HIGHT-2 and IMAGE_HIGHT-1 with a zero bottom row.
    - Emits IMAGE_WIDTH windows for line IMAGE_HIGHT-1; the last one has m_last = 1.
    - On that window's handshake: go to FILL with counters cleared.
- Output register:
  - m_valid rises one cycle after the step that forms a window.
  - While m_valid && !m_ready, all of m_win, m_x, m_y, m_last hold, and no shifter step occurs in any state.
  - Back-to-back windows at full rate when m_ready = 1.
- Rate and latency:
  - Exactly IMAGE_WIDTH*IMAGE_HIGHT windows per frame, in raster order of their centre.
  - Pixels are never dropped or duplicated under any s_valid/m_ready pattern.
  - Latency from the accept of pixel (x+1, y+1) to m_valid for centre (x,y) is 1 cycle.
- No data from a previous frame appears in any window. The top row of line-0 windows is forced to 0, not read from the banks.

Test Plan (IMAGE_WIDTH_E = 2, IMAGE_HIGHT_E = 2, pixel p(x,y) = 16y + x + 1):
- Reset: hold reset = 0 for 3 cycles with s_valid = 1 -> m_valid = 0, m_win = 0, s_ready = 0; s_ready = 1 on the first cycle after release.
- Full frame, m_ready = 1:
  - First m_valid comes 1 cycle after p(1,1) is accepted: centre (0,0), m_win rows {0,0,0 | 0,1,2 | 0,17,18}.
  - 16 windows in total. The last has centre (3,3), rows {35,36,0 | 51,52,0 | 0,0,0}, m_last = 1.
  - m_last = 0 on every other window.
- Backpressure: m_ready = 0 for 5 cycles on the window centred (1,1) -> outputs stable, s_ready = 0; the resulting window sequence is identical to the full-frame case.
- Input bubbles: s_valid toggling 1/0 every cycle -> same 16 windows and values as the full-frame case; no output during FILL.
- Reset mid-frame: assert reset after p(2,2) is accepted, then send a clean frame -> output identical to the full-frame case with no stale pixels.
- Back-to-back frames: second frame with p'(x,y) = 100 + x -> its first window's top row is {0,0,0}; its m_last window's bottom row is {0,0,0}.
